psum_writeback_stage: RTL

//  Write-side counterpart of the PE fetch path: accepts per-row partial sums from the accumulate stage
//  and writes them back into the psum pad (PP). Packs results for the pad's psum mode:

---
 rtl/psum_writeback_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/psum_writeback_stage.sv
// psum_writeback_stage: writes accumulate-stage partial sums back into the psum pad.
// Packs each PE row as a full PSUMDWD word or a DWD half-word placed by parity,
// arbitrates for the shared pad write port and reports tile completion to PE control.
// Optional feature macro: PSUM_SAT_EN (signed saturation of D16 half-words instead of truncation).
`timescale 1ns/1ps

module psum_writeback_stage #(
   parameter int DWD     = 8,
   parameter int PSUMDWD = 16,
   parameter int PEROW   = 4,
   parameter int ADDRWD  = 5,
   parameter int CNTWD   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     AS_rdy,
   output logic                     AS_ack,
   input  logic [PEROW*PSUMDWD-1:0] i_psum,
   input  logic                     i_psum_mode,
   input  logic                     i_parity,
   input  logic [ADDRWD-1:0]        i_addr,
   input  logic                     i_last,
   output logic                     o_pp_we,
   input  logic                     i_pp_gnt,
   output logic [ADDRWD-1:0]        o_pp_addr,
   output logic [PEROW*PSUMDWD-1:0] o_pp_wdata,
   output logic [PEROW*2-1:0]       o_pp_wmask,
   output logic                     WB_rdy,
   input  logic                     WB_ack,
   output logic [CNTWD-1:0]         o_wcnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      DONE     = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [ADDRWD-1:0]          addr_q;
   logic [PEROW*PSUMDWD-1:0]   wdata_q;
   logic [PEROW*2-1:0]         wmask_q;
   logic                       last_q;
   logic [CNTWD-1:0]           wcnt_q, wcnt_d;

   logic                       load;
   logic                       ack_c;
   logic                       we_c;
   logic                       wb_rdy_c;
   logic [PEROW*PSUMDWD-1:0]   pack_data;
   logic [PEROW*2-1:0]         pack_mask;
   logic [PSUMDWD-1:0]         row;
   logic [DWD-1:0]             half;
`ifdef PSUM_SAT_EN
   logic [PSUMDWD-DWD:0]       row_upper;
`endif

   // Pack the incoming per-row sums into pad word layout before they are registered.
   // The packed form is held instead of the raw sums, so the pad sees registered data directly.
   always_comb begin
      pack_data = '0;
      pack_mask = '0;
      row       = '0;
      half      = '0;
`ifdef PSUM_SAT_EN
      row_upper = '0;
`endif
      for (int unsigned r = 0; r < PEROW; r++) begin
         row = i_psum[r*PSUMDWD +: PSUMDWD];
         if (!i_psum_mode) begin
            pack_data[r*PSUMDWD +: PSUMDWD] = row;
            pack_mask[r*2 +: 2]             = 2'b11;
         end else begin
`ifdef PSUM_SAT_EN
            // Value fits in DWD signed bits when everything from the DWD-1 bit upward is a sign copy.
            row_upper = row[PSUMDWD-1:DWD-1];
            if ((row_upper == '0) || (row_upper == '1)) begin
               half = row[DWD-1:0];
            end else if (row[PSUMDWD-1]) begin
               half = {1'b1, {(DWD-1){1'b0}}};
            end else begin
               half = {1'b0, {(DWD-1){1'b1}}};
            end
`else
            half = row[DWD-1:0];
`endif
            if (i_parity) begin
               pack_data[r*PSUMDWD+DWD +: DWD] = half;
               pack_mask[r*2 +: 2]             = 2'b10;
            end else begin
               pack_data[r*PSUMDWD +: DWD]     = half;
               pack_mask[r*2 +: 2]             = 2'b01;
            end
         end
      end
   end

   // Next-state, handshake outputs and commit counter update.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      load     = 1'b0;
      ack_c    = 1'b0;
      we_c     = 1'b0;
      wb_rdy_c = 1'b0;
      case (state_q)
         IDLE: begin
            ack_c = AS_rdy;
            if (AS_rdy) begin
               load    = 1'b1;
               state_d = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            we_c = 1'b1;
            if (i_pp_gnt) begin
               wcnt_d  = wcnt_q + 1'b1;
               state_d = last_q ? DONE : IDLE;
            end
         end
         DONE: begin
            wb_rdy_c = 1'b1;
            if (WB_ack) begin
               wcnt_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and commit counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Holding registers for the pending pad write; stable until the grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         last_q  <= 1'b0;
      end else if (load) begin
         addr_q  <= i_addr;
         wdata_q <= pack_data;
         wmask_q <= pack_mask;
         last_q  <= i_last;
      end
   end

   assign AS_ack     = ack_c;
   assign o_pp_we    = we_c;
   assign o_pp_addr  = addr_q;
   assign o_pp_wdata = wdata_q;
   assign o_pp_wmask = wmask_q;
   assign WB_rdy     = wb_rdy_c;
   assign o_wcnt     = wcnt_q;

endmodule
